unibus_burst_memory: RTL and testbench

Parametrised successor to the single-beat unified-bus memory: a synchronous RAM that takes a command (op, address, beat count) and then moves one or more data beats over a shared multiplexed data bus. It adds configurable width, depth and read latency, incrementing bursts with address wrap-around, and a done pulse. The bus is split into in, out and output-enable at this boundary; the tri-state driver lives in the top level.

---
 rtl/unibus_pkg.sv | 14 +
 rtl/unibus_ram_core.sv | 22 ++
 rtl/unibus_burst_memory.sv | 136 +++++++++++++
 tb/tb_unibus_burst_memory.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/unibus_pkg.sv
// Shared definitions for the unified-bus burst memory: command encoding and controller states.
package unibus_pkg;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        RWAIT,
        RDATA
    } state_t;

endpackage

// File: rtl/unibus_ram_core.sv
// Single-port synchronous RAM with a one-cycle registered read (read-before-write on a shared address).
module unibus_ram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/unibus_burst_memory.sv
// Burst memory on a split unified bus: a command (op, start address, beat count) is followed by
// incrementing data beats with natural address wrap-around, then a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for req; captures rw, addr and burst_len when it arrives
// WDATA | one write beat per cycle taken from bus_in
// RWAIT | read latency countdown; issues the first RAM read on its last cycle
// RDATA | one read beat per cycle on bus_out; issues the following RAM read
module unibus_burst_memory
    import unibus_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 4,
    parameter int READ_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              busy,
    output logic              done
);

    localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [LEN_W-1:0]  beat_q, beat_nxt;
    logic [WAIT_W-1:0] wait_q, wait_nxt;
    logic              rd_issue;
    logic              done_nxt;
    logic              wr_beat;
    logic              ram_we;
    logic              oe_q;
    logic              done_q;
    logic [DATA_W-1:0] ram_rdata;

    // A write beat coinciding with reset must not land; reset abandons the rest of the burst.
    assign ram_we = wr_beat & ~RST;

    unibus_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (bus_in),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        len_nxt   = len_q;
        beat_nxt  = beat_q;
        wait_nxt  = wait_q;
        rd_issue  = 1'b0;
        done_nxt  = 1'b0;
        wr_beat   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    addr_nxt  = addr;
                    len_nxt   = burst_len;
                    beat_nxt  = '0;
                    wait_nxt  = WAIT_W'(READ_LAT - 1);
                    state_nxt = (rw == OP_WRITE) ? WDATA : RWAIT;
                end
            end
            WDATA: begin
                wr_beat  = 1'b1;
                addr_nxt = addr_q + 1'b1;
                beat_nxt = beat_q + 1'b1;
                if (beat_q == len_q) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            RWAIT: begin
                // The RAM adds one more cycle, so the countdown covers READ_LAT-1 cycles.
                if (wait_q == '0) begin
                    rd_issue  = 1'b1;
                    addr_nxt  = addr_q + 1'b1;
                    state_nxt = RDATA;
                end else begin
                    wait_nxt = wait_q - 1'b1;
                end
            end
            RDATA: begin
                if (beat_q == len_q) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    rd_issue = 1'b1;
                    addr_nxt = addr_q + 1'b1;
                    beat_nxt = beat_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            addr_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
            wait_q <= '0;
            oe_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            len_q  <= len_nxt;
            beat_q <= beat_nxt;
            wait_q <= wait_nxt;
            oe_q   <= rd_issue;
            done_q <= done_nxt;
        end
    end

    assign bus_out = oe_q ? ram_rdata : '0;
    assign bus_oe  = oe_q;
    assign busy    = (state != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_unibus_burst_memory.sv
// Scoreboard bench: two instances (READ_LAT 2 and 4) driven with directed and random bursts,
// checked cycle by cycle against an array model of the memory and command timing.
module tb_unibus_burst_memory;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } beat_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] req = 2'b00;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [3:0] burst_len = 4'h0;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] bus_out_w [2];
    logic       bus_oe_w [2];
    logic       busy_w [2];
    logic       done_w [2];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    int         rl [2] = '{2, 4};
    logic [7:0] mem [2][256];
    logic [7:0] wdat [16];
    beat_t      exp_beats [2][$];
    int         done_q [2][$];
    int         busy_from [2] = '{0, 0};
    int         busy_until [2] = '{0, 0};
    int         next_free [2] = '{0, 0};

    logic       m_oe, m_done;
    logic [7:0] m_data;
    beat_t      m_b;
    int         m_d;

    unibus_burst_memory #(.DATA_W(8), .ADDR_W(8), .LEN_W(4), .READ_LAT(2)) dut2 (
        .CLK(CLK), .RST(RST), .req(req[0]), .rw(rw), .addr(addr), .burst_len(burst_len),
        .bus_in(bus_in), .bus_out(bus_out_w[0]), .bus_oe(bus_oe_w[0]), .busy(busy_w[0]),
        .done(done_w[0])
    );

    unibus_burst_memory #(.DATA_W(8), .ADDR_W(8), .LEN_W(4), .READ_LAT(4)) dut4 (
        .CLK(CLK), .RST(RST), .req(req[1]), .rw(rw), .addr(addr), .burst_len(burst_len),
        .bus_in(bus_in), .bus_out(bus_out_w[1]), .bus_oe(bus_oe_w[1]), .busy(busy_w[1]),
        .done(done_w[1])
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle, compare outputs with what the model says should be on the bus.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            m_oe   = 1'b0;
            m_data = 8'h00;
            m_done = 1'b0;
            if (exp_beats[i].size() > 0 && exp_beats[i][0].cyc == cyc) begin
                m_b    = exp_beats[i].pop_front();
                m_oe   = 1'b1;
                m_data = m_b.data;
            end
            if (done_q[i].size() > 0 && done_q[i][0] == cyc) begin
                m_d    = done_q[i].pop_front();
                m_done = 1'b1;
            end
            check("bus_oe", i, 32'(bus_oe_w[i]), 32'(m_oe));
            check("bus_out", i, 32'(bus_out_w[i]), 32'(m_data));
            check("done", i, 32'(done_w[i]), 32'(m_done));
            check("busy", i, 32'(busy_w[i]),
                  32'((cyc >= busy_from[i] && cyc < busy_until[i]) ? 1 : 0));
        end
    end

    task automatic flush(input int r);
        for (int i = 0; i < 2; i++) begin
            exp_beats[i].delete();
            done_q[i].delete();
            busy_until[i] = 0;
            next_free[i]  = r + 1;
        end
    endtask

    // Issues one command to instance i; called #1 after a rising edge and returns #1 after one.
    // For writes, rst_beat >= 0 asserts RST in place of that beat's sampling edge.
    task automatic cmd(input int i, input bit r, input logic [7:0] a, input logic [3:0] l,
                       input bit wf, input int rst_beat);
        int         n;
        bit         acc;
        beat_t      b;
        logic [7:0] idx;
        if (wf) begin
            while (cyc + 1 < next_free[i]) begin
                @(posedge CLK);
                #1;
            end
        end
        req[i]    = 1'b1;
        rw        = r;
        addr      = a;
        burst_len = l;
        @(posedge CLK);
        #1;
        n      = cyc;
        req[i] = 1'b0;
        acc    = (n >= next_free[i]);
        if (acc) begin
            busy_from[i] = n;
            if (r) begin
                for (int k = 0; k <= int'(l); k++) begin
                    idx    = a + 8'(k);
                    b.cyc  = n + rl[i] + k;
                    b.data = mem[i][idx];
                    exp_beats[i].push_back(b);
                end
                busy_until[i] = n + rl[i] + int'(l) + 1;
            end else begin
                busy_until[i] = n + int'(l) + 1;
            end
            done_q[i].push_back(busy_until[i]);
            next_free[i] = busy_until[i] + 1;
        end
        if (!r) begin
            for (int k = 0; k <= int'(l); k++) begin
                bus_in = wdat[k];
                if (k == rst_beat) begin
                    RST = 1'b1;
                    @(posedge CLK);
                    #1;
                    RST = 1'b0;
                    flush(cyc);
                    break;
                end
                @(posedge CLK);
                #1;
                if (acc) begin
                    idx = a + 8'(k);
                    mem[i][idx] = wdat[k];
                end
            end
        end
    endtask

    initial begin
        // Reset held with req high on both instances: nothing may start.
        req = 2'b11;
        rw  = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        req = 2'b00;
        flush(cyc);

        for (int i = 0; i < 2; i++) begin
            for (int blk = 0; blk < 16; blk++) begin
                for (int k = 0; k < 16; k++) wdat[k] = 8'($urandom);
                cmd(i, 1'b0, 8'(blk * 16), 4'hF, 1'b1, -1);
            end
        end

        // Single-beat writes near the top of memory, then a single-beat read.
        wdat[0] = 8'hAA; cmd(0, 1'b0, 8'hFF, 4'h0, 1'b1, -1);
        wdat[0] = 8'hAB; cmd(0, 1'b0, 8'hFE, 4'h0, 1'b1, -1);
        wdat[0] = 8'hAC; cmd(0, 1'b0, 8'hFD, 4'h0, 1'b1, -1);
        cmd(0, 1'b1, 8'hFF, 4'h0, 1'b1, -1);

        // Four-beat wrapping write then read-back.
        wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
        cmd(0, 1'b0, 8'hFE, 4'h3, 1'b1, -1);
        cmd(0, 1'b1, 8'hFE, 4'h3, 1'b1, -1);
        cmd(0, 1'b1, 8'h00, 4'h1, 1'b1, -1);

        // Write request during a read is ignored.
        cmd(0, 1'b1, 8'h08, 4'h7, 1'b1, -1);
        wdat[0] = 8'h5A;
        cmd(0, 1'b0, 8'h10, 4'h0, 1'b0, -1);
        cmd(0, 1'b1, 8'h10, 4'h0, 1'b1, -1);

        // Reset after two beats of a four-beat write.
        for (int k = 0; k < 4; k++) wdat[k] = 8'($urandom);
        cmd(0, 1'b0, 8'h20, 4'h3, 1'b1, 2);
        cmd(0, 1'b1, 8'h20, 4'h3, 1'b1, -1);

        // Longer read latency instance.
        cmd(1, 1'b1, 8'h40, 4'h2, 1'b1, -1);

        // Read accepted in the done cycle of a write, full 16-beat wrap.
        wdat[0] = 8'h77;
        cmd(0, 1'b0, 8'h80, 4'h0, 1'b1, -1);
        cmd(0, 1'b1, 8'hF8, 4'hF, 1'b1, -1);

        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 16; k++) wdat[k] = 8'($urandom);
            cmd($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom),
                4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0), -1);
        end

        for (int t = 0; t < 400; t++) begin
            if (exp_beats[0].size() == 0 && exp_beats[1].size() == 0 &&
                done_q[0].size() == 0 && done_q[1].size() == 0) break;
            @(posedge CLK);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("drain_beats", i, 32'(exp_beats[i].size()), 32'd0);
            check("drain_done", i, 32'(done_q[i].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
